serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_ctrl_full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    // Controller states: waiting, shifting bits, presenting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width used when the instantiating level does not override it.
    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: a + b + cin computed LSB first through one full-adder
// cell, one bit per clock, under an IDLE/RUN/DONE controller.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter only ever reaches WIDTH-1, so $clog2(WIDTH) bits never wrap.
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic             last_bit_s;
    logic             accept_s;

    full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    assign last_bit_s = (cnt_r == CNT_LAST);
    assign accept_s   = (state_r == IDLE) && start;

    // Controller: state, bit counter and registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_bit_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand shift registers, carry chain and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
        end else if (state_r == RUN) begin
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
            carry_r <= fa_cout_s;
            if (last_bit_s) begin
                // carry_r here is the carry into the MSB.
                cout_r <= fa_cout_s;
                ovf_r  <= carry_r ^ fa_cout_s;
            end else begin
                cout_r <= cout_r;
                ovf_r  <= ovf_r;
            end
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            carry_r <= carry_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table,
// result scoreboard and hand-written multi-cycle corner cases.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    res_t sb_q[$];
    vec_t vecs[8];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        res_t       r;
        logic [W:0] t;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        res_t e;
        if (busy && done) begin
            check("busy_and_done", 32'(busy & done), 32'd0);
        end
        if (rst_n && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_sum",  32'(sum),  32'(e.s));
                check("sb_cout", 32'(cout), 32'(e.c));
                check("sb_ovf",  32'(ovf),  32'(e.o));
            end
        end
    end

    // One full operation with cycle-accurate busy/done and hold checks.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        res_t r;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        r.s = es; r.c = ec; r.o = eo;
        sb_q.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int j = 0; j <= W; j++) begin
            if (j > 0) @(posedge clk);
            @(negedge clk);
            check("op_busy", 32'(busy), (j < W) ? 32'd1 : 32'd0);
            check("op_done", 32'(done), (j == W) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("hold_done", 32'(done), 32'd0);
        check("hold_sum",  32'(sum),  32'(es));
        check("hold_cout", 32'(cout), 32'(ec));
        check("hold_ovf",  32'(ovf),  32'(eo));
    endtask

    initial begin
        int   d0;
        res_t r;

        vecs[0] = '{a: 8'd3,   b: 8'd5,   cin: 1'b0, s: 8'd8,   c: 1'b0, o: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd0,   cin: 1'b1, s: 8'd0,   c: 1'b1, o: 1'b0};
        vecs[2] = '{a: 8'd127, b: 8'd1,   cin: 1'b0, s: 8'd128, c: 1'b0, o: 1'b1};
        vecs[3] = '{a: 8'd128, b: 8'd128, cin: 1'b0, s: 8'd0,   c: 1'b1, o: 1'b1};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   cin: 1'b0, s: 8'd0,   c: 1'b0, o: 1'b0};
        vecs[5] = '{a: 8'd200, b: 8'd100, cin: 1'b1, s: 8'd45,  c: 1'b1, o: 1'b0};
        vecs[6] = '{a: 8'd100, b: 8'd50,  cin: 1'b0, s: 8'd150, c: 1'b0, o: 1'b1};
        vecs[7] = '{a: 8'd170, b: 8'd85,  cin: 1'b1, s: 8'd0,   c: 1'b1, o: 1'b0};

        // Reset state.
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o);
        end

        // Start re-pulsed during RUN is ignored.
        d0 = done_cnt;
        @(negedge clk);
        a = 8'd10; b = 8'd20; cin = 1'b0; start = 1'b1;
        sb_q.push_back(model(8'd10, 8'd20, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'd77; b = 8'd88; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
        check("restart_done_seen", 32'(done_cnt - d0), 32'd1);
        repeat (12) @(negedge clk);
        check("restart_single_done", 32'(done_cnt - d0), 32'd1);
        check("restart_sum_held", 32'(sum), 32'd30);

        // Reset mid-RUN aborts without a done pulse.
        d0 = done_cnt;
        @(negedge clk);
        a = 8'd50; b = 8'd60; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        r = model(8'd50, 8'd60, 1'b0);
        run_op(8'd50, 8'd60, 1'b0, r.s, r.c, r.o);

        // Start held high: accepted every WIDTH+2 edges.
        d0 = done_cnt;
        for (int t = 0; t <= 30; t++) begin
            @(negedge clk);
            if (t > 0) begin
                check("b2b_done", 32'(done), ((t % 10) == 9) ? 32'd1 : 32'd0);
            end
            if (t == 0)  begin a = 8'd1;   b = 8'd2;   cin = 1'b0; sb_q.push_back(model(a, b, cin)); end
            if (t == 10) begin a = 8'd100; b = 8'd27;  cin = 1'b1; sb_q.push_back(model(a, b, cin)); end
            if (t == 20) begin a = 8'd255; b = 8'd255; cin = 1'b1; sb_q.push_back(model(a, b, cin)); end
            if (t == 30) start = 1'b0;
            else         start = 1'b1;
            if (t == 3 || t == 13 || t == 23) begin
                a = W'($urandom); b = W'($urandom);
            end
        end
        repeat (3) @(negedge clk);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog: guarantees termination if the DUT wedges.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_adder_ctrl
